// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL controller: FSM states, ctrl_status codes,
// applied mul/div reset values and a counter-width helper.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_PRST,
    ST_WAIT_LOCK,
    ST_RUN,
    ST_FAULT
  } state_e;

  typedef enum logic [1:0] {
    STATUS_OFF   = 2'b00,
    STATUS_RUN   = 2'b01,
    STATUS_BUSY  = 2'b10,
    STATUS_FAULT = 2'b11
  } status_e;

  localparam logic [7:0] MUL_RESET = 8'd1;
  localparam logic [7:0] DIV_RESET = 8'd1;

  // Bits needed to hold (max_count - 1); never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

  function automatic status_e status_of(input state_e st);
    case (st)
      ST_RUN:                return STATUS_RUN;
      ST_PRST, ST_WAIT_LOCK: return STATUS_BUSY;
      ST_FAULT:              return STATUS_FAULT;
      default:               return STATUS_OFF;
    endcase
  endfunction

endpackage

// File: rtl/pll_ctrl_timer.sv
// Loadable down-counter shared by the PRST hold and the lock timeout.
// done_o is high whenever the count has reached zero; load takes priority over counting.
module pll_ctrl_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             done_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/pll_ctrl.sv
// PLL bring-up controller: config handshake, reset/lock sequencing, lock-loss recovery and faults.
// Define PLL_CTRL_TIMEOUT_EN to bound each lock attempt by LOCK_TIMEOUT and retry up to MAX_RETRY times.
module pll_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned LOCK_TIMEOUT = 64,
  parameter int unsigned MAX_RETRY    = 2
) (
  input  logic       xo_clk,
  input  logic       reset,
  input  logic       cfg_req,
  input  logic [7:0] cfg_mul,
  input  logic [7:0] cfg_div,
  input  logic       cfg_bypass,
  input  logic       disable_req,
  input  logic       pll_locked,
  input  logic       pll_error,
  output logic       pll_enable,
  output logic       pll_bypass,
  output logic       pll_reset,
  output logic [7:0] pll_mul,
  output logic [7:0] pll_div,
  output logic       clk_sel,
  output logic       cfg_ack,
  output logic       cfg_err,
  output logic [1:0] ctrl_status,
  output logic       fault_irq
);

  localparam int unsigned TIMER_W =
    cnt_width((RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT);
  localparam logic [TIMER_W-1:0] PRST_LOAD = TIMER_W'(RESET_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WAIT_LOAD = TIMER_W'(LOCK_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] mul_q, mul_d;
  logic [7:0] div_q, div_d;
  logic       bypass_q, bypass_d;
  logic       enable_q, enable_d;
  logic       prst_q, prst_d;
  logic       sel_q, sel_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;
  status_e    status_q, status_d;
  logic       irq_q, irq_d;

  logic               take_cfg;
  logic               cfg_valid;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_val;
  logic               timer_done;

`ifdef PLL_CTRL_TIMEOUT_EN
  localparam int unsigned RETRY_W = cnt_width(MAX_RETRY + 1);
  logic [RETRY_W-1:0] retry_q, retry_d;
`endif

  assign cfg_valid = (cfg_mul != 8'd0) && (cfg_div != 8'd0);

  always_comb begin
    state_d  = state_q;
    mul_d    = mul_q;
    div_d    = div_q;
    bypass_d = bypass_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    take_cfg = 1'b0;
`ifdef PLL_CTRL_TIMEOUT_EN
    retry_d  = retry_q;
`endif

    if (disable_req) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF, ST_FAULT: take_cfg = cfg_req;
        ST_PRST: begin
          if (timer_done) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (pll_error) begin
            state_d = ST_FAULT;
          end else if (pll_locked) begin
            state_d = ST_RUN;
          end
`ifdef PLL_CTRL_TIMEOUT_EN
          else if (timer_done) begin
            if (retry_q < RETRY_W'(MAX_RETRY)) begin
              retry_d = retry_q + 1'b1;
              state_d = ST_PRST;
            end else begin
              state_d = ST_FAULT;
            end
          end
`endif
        end
        ST_RUN: begin
          // A pending request is served before lock loss; an error outranks both.
          if (pll_error) begin
            state_d = ST_FAULT;
          end else if (cfg_req) begin
            take_cfg = 1'b1;
          end else if (!pll_locked) begin
            state_d = ST_WAIT_LOCK;
`ifdef PLL_CTRL_TIMEOUT_EN
            retry_d = '0;
`endif
          end
        end
        default: state_d = ST_OFF;
      endcase
    end

    if (take_cfg) begin
      if (cfg_valid) begin
        ack_d    = 1'b1;
        mul_d    = cfg_mul;
        div_d    = cfg_div;
        bypass_d = cfg_bypass;
        state_d  = ST_PRST;
`ifdef PLL_CTRL_TIMEOUT_EN
        retry_d  = '0;
`endif
      end else begin
        err_d = 1'b1;
      end
    end

    // Outputs are registered from the next state so they line up with the state register.
    enable_d = (state_d == ST_PRST) || (state_d == ST_WAIT_LOCK) || (state_d == ST_RUN);
    prst_d   = (state_d == ST_PRST);
    sel_d    = (state_q == ST_RUN) && (state_d == ST_RUN) && !bypass_q;
    status_d = status_of(state_d);
    irq_d    = (state_d == ST_FAULT) && (state_q != ST_FAULT);

    timer_load = (state_d != state_q) &&
                 ((state_d == ST_PRST) || (state_d == ST_WAIT_LOCK));
    timer_val  = (state_d == ST_PRST) ? PRST_LOAD : WAIT_LOAD;
  end

  pll_ctrl_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk_i     (xo_clk),
    .reset_i   (reset),
    .load_i    (timer_load),
    .load_val_i(timer_val),
    .done_o    (timer_done)
  );

  always_ff @(posedge xo_clk) begin
    if (reset) begin
      state_q  <= ST_OFF;
      mul_q    <= MUL_RESET;
      div_q    <= DIV_RESET;
      bypass_q <= 1'b0;
      enable_q <= 1'b0;
      prst_q   <= 1'b1;
      sel_q    <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      status_q <= STATUS_OFF;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mul_q    <= mul_d;
      div_q    <= div_d;
      bypass_q <= bypass_d;
      enable_q <= enable_d;
      prst_q   <= prst_d;
      sel_q    <= sel_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      status_q <= status_d;
      irq_q    <= irq_d;
    end
  end

`ifdef PLL_CTRL_TIMEOUT_EN
  always_ff @(posedge xo_clk) begin
    if (reset) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  assign pll_enable  = enable_q;
  assign pll_bypass  = bypass_q;
  assign pll_reset   = prst_q;
  assign pll_mul     = mul_q;
  assign pll_div     = div_q;
  assign clk_sel     = sel_q;
  assign cfg_ack     = ack_q;
  assign cfg_err     = err_q;
  assign ctrl_status = status_q;
  assign fault_irq   = irq_q;

endmodule

// File: tb/tb_pll_ctrl.sv
// Scoreboard bench for pll_ctrl: each stimulus cycle queues the expected output vector,
// which a monitor pops and compares one step after the following clock edge.
module tb_pll_ctrl;

  localparam int unsigned RC = 4;
  localparam int unsigned LT = 64;
  localparam int unsigned MR = 2;

  logic       xo_clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_req = 1'b0;
  logic [7:0] cfg_mul = 8'd0;
  logic [7:0] cfg_div = 8'd0;
  logic       cfg_bypass = 1'b0;
  logic       disable_req = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_error = 1'b0;
  logic       pll_enable, pll_bypass, pll_reset, clk_sel;
  logic       cfg_ack, cfg_err, fault_irq;
  logic [7:0] pll_mul, pll_div;
  logic [1:0] ctrl_status;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [24:0] exp;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  sb_entry_t   mon_e;
  logic [24:0] obs;

  pll_ctrl #(
    .RESET_CYCLES(RC),
    .LOCK_TIMEOUT(LT),
    .MAX_RETRY   (MR)
  ) dut (
    .xo_clk     (xo_clk),
    .reset      (reset),
    .cfg_req    (cfg_req),
    .cfg_mul    (cfg_mul),
    .cfg_div    (cfg_div),
    .cfg_bypass (cfg_bypass),
    .disable_req(disable_req),
    .pll_locked (pll_locked),
    .pll_error  (pll_error),
    .pll_enable (pll_enable),
    .pll_bypass (pll_bypass),
    .pll_reset  (pll_reset),
    .pll_mul    (pll_mul),
    .pll_div    (pll_div),
    .clk_sel    (clk_sel),
    .cfg_ack    (cfg_ack),
    .cfg_err    (cfg_err),
    .ctrl_status(ctrl_status),
    .fault_irq  (fault_irq)
  );

  always #5 xo_clk = ~xo_clk;

  assign obs = {pll_enable, pll_bypass, pll_reset, pll_mul, pll_div,
                clk_sel, cfg_ack, cfg_err, ctrl_status, fault_irq};

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (en,byp,rst,mul,div,sel,ack,err,st,irq)",
               tag, observed, expected);
    end
  endtask

  function automatic logic [24:0] mk(input logic en, input logic byp, input logic rst,
                                      input logic [7:0] mul, input logic [7:0] div,
                                      input logic sel, input logic ack, input logic err,
                                      input logic [1:0] st, input logic irq);
    return {en, byp, rst, mul, div, sel, ack, err, st, irq};
  endfunction

  always @(posedge xo_clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check(mon_e.tag, {7'd0, obs}, {7'd0, mon_e.exp});
    end
  end

  // Inputs change on the falling edge; the expectation is for the next rising edge.
  task automatic cyc(input string tag, input logic [24:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    @(negedge xo_clk);
  endtask

  // Valid request from an accepting state through PRST to the first WAIT_LOCK cycle.
  task automatic start_cfg(input string tag, input logic [7:0] m, input logic [7:0] d, input logic b);
    cfg_req = 1'b1; cfg_mul = m; cfg_div = d; cfg_bypass = b;
    cyc({tag, "_ack"}, mk(1, b, 1, m, d, 0, 1, 0, 2'b10, 0));
    cfg_req = 1'b0;
    for (int i = 1; i < RC; i++) cyc({tag, "_prst"}, mk(1, b, 1, m, d, 0, 0, 0, 2'b10, 0));
    cyc({tag, "_wait"}, mk(1, b, 0, m, d, 0, 0, 0, 2'b10, 0));
  endtask

  localparam logic [24:0] RST_OUT = 25'({1'b0, 1'b0, 1'b1, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0});

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge xo_clk);
    cyc("rst_a", RST_OUT);
    cyc("rst_b", RST_OUT);
    reset = 1'b0;
    cyc("rst_release", mk(0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 0));

    // Invalid divider in OFF.
    cfg_req = 1'b1; cfg_mul = 8'd4; cfg_div = 8'd0;
    cyc("bad_div", mk(0, 0, 0, 1, 1, 0, 0, 1, 2'b00, 0));
    cfg_req = 1'b0;
    cyc("bad_div_idle", mk(0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 0));

    // Valid bring-up; lock three cycles after pll_reset falls.
    start_cfg("cfg42", 8'd4, 8'd2, 1'b0);
    cyc("lock_wait", mk(1, 0, 0, 4, 2, 0, 0, 0, 2'b10, 0));
    cyc("lock_wait", mk(1, 0, 0, 4, 2, 0, 0, 0, 2'b10, 0));
    pll_locked = 1'b1;
    cyc("run_entry", mk(1, 0, 0, 4, 2, 0, 0, 0, 2'b01, 0));
    cyc("run_sel", mk(1, 0, 0, 4, 2, 1, 0, 0, 2'b01, 0));

    // One-cycle lock loss and relock.
    pll_locked = 1'b0;
    cyc("lock_loss", mk(1, 0, 0, 4, 2, 0, 0, 0, 2'b10, 0));
    pll_locked = 1'b1;
    cyc("relock", mk(1, 0, 0, 4, 2, 0, 0, 0, 2'b01, 0));
    cyc("relock_sel", mk(1, 0, 0, 4, 2, 1, 0, 0, 2'b01, 0));

    // disable_req beats cfg_req in RUN.
    cfg_req = 1'b1; cfg_mul = 8'd6; cfg_div = 8'd3; cfg_bypass = 1'b1; disable_req = 1'b1;
    cyc("dis_pri", mk(0, 0, 0, 4, 2, 0, 0, 0, 2'b00, 0));
    cfg_req = 1'b0; disable_req = 1'b0; pll_locked = 1'b0;
    cyc("off_hold", mk(0, 0, 0, 4, 2, 0, 0, 0, 2'b00, 0));

    // pll_error and pll_locked together in WAIT_LOCK go to FAULT.
    start_cfg("cfg53", 8'd5, 8'd3, 1'b1);
    pll_locked = 1'b1; pll_error = 1'b1;
    cyc("err_pri", mk(0, 1, 0, 5, 3, 0, 0, 0, 2'b11, 1));
    pll_locked = 1'b0; pll_error = 1'b0;
    cyc("fault_hold", mk(0, 1, 0, 5, 3, 0, 0, 0, 2'b11, 0));
    cfg_req = 1'b1; cfg_mul = 8'd0; cfg_div = 8'd9; cfg_bypass = 1'b0;
    cyc("bad_mul_fault", mk(0, 1, 0, 5, 3, 0, 0, 1, 2'b11, 0));
    cfg_req = 1'b0;

    // Recovery from FAULT in bypass mode, then a RUN-state error.
    start_cfg("cfg88", 8'd8, 8'd8, 1'b1);
    pll_locked = 1'b1;
    cyc("byp_run", mk(1, 1, 0, 8, 8, 0, 0, 0, 2'b01, 0));
    cyc("byp_sel", mk(1, 1, 0, 8, 8, 0, 0, 0, 2'b01, 0));
    pll_error = 1'b1;
    cyc("run_err", mk(0, 1, 0, 8, 8, 0, 0, 0, 2'b11, 1));
    pll_error = 1'b0; pll_locked = 1'b0; disable_req = 1'b1;
    cyc("fault_off", mk(0, 1, 0, 8, 8, 0, 0, 0, 2'b00, 0));
    disable_req = 1'b0;

    // Request pending during PRST, then disable_req aborts.
    cfg_req = 1'b1; cfg_mul = 8'd3; cfg_div = 8'd1; cfg_bypass = 1'b0;
    cyc("p_ack", mk(1, 0, 1, 3, 1, 0, 1, 0, 2'b10, 0));
    cfg_mul = 8'd9; cfg_div = 8'd9;
    cyc("prst_pend", mk(1, 0, 1, 3, 1, 0, 0, 0, 2'b10, 0));
    disable_req = 1'b1;
    cyc("prst_dis", mk(0, 0, 0, 3, 1, 0, 0, 0, 2'b00, 0));
    disable_req = 1'b0; cfg_req = 1'b0;

    // Reset while in WAIT_LOCK with a request pending.
    start_cfg("cfg23", 8'd2, 8'd3, 1'b0);
    cfg_req = 1'b1; cfg_mul = 8'd7; cfg_div = 8'd7;
    cyc("wait_pend", mk(1, 0, 0, 2, 3, 0, 0, 0, 2'b10, 0));
    reset = 1'b1;
    cyc("rst_wait", RST_OUT);
    reset = 1'b0; cfg_req = 1'b0;
    cyc("rst_wait_rel", mk(0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 0));

`ifdef PLL_CTRL_TIMEOUT_EN
    // Three full attempts without lock, then FAULT.
    cfg_mul = 8'd4; cfg_div = 8'd2; cfg_bypass = 1'b0;
    for (int a = 0; a <= int'(MR); a++) begin
      for (int i = 0; i < int'(RC + LT); i++) begin
        cfg_req = (a == 0 && i == 0);
        if (i < int'(RC)) cyc("to_prst", mk(1, 0, 1, 4, 2, 0, (a == 0 && i == 0), 0, 2'b10, 0));
        else              cyc("to_wait", mk(1, 0, 0, 4, 2, 0, 0, 0, 2'b10, 0));
      end
    end
    cfg_req = 1'b0;
    cyc("to_fault", mk(0, 0, 0, 4, 2, 0, 0, 0, 2'b11, 1));
    cyc("to_fault_hold", mk(0, 0, 0, 4, 2, 0, 0, 0, 2'b11, 0));
`else
    // Without the timeout, WAIT_LOCK holds well past LOCK_TIMEOUT.
    start_cfg("nto", 8'd4, 8'd2, 1'b0);
    for (int i = 0; i < int'(RC + LT); i++) cyc("nto_wait", mk(1, 0, 0, 4, 2, 0, 0, 0, 2'b10, 0));
`endif
    disable_req = 1'b1;
    cyc("final_off", mk(0, 0, 0, 4, 2, 0, 0, 0, 2'b00, 0));
    disable_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
